// File: rtl/nco_phase_bank.sv
// nco_phase_bank: multi-channel programmable NCO phase generator for the
// CORDIC down/up-conversion chain. Each channel has a run-time increment and
// phase offset. Both are double-buffered: writes go to shadow registers, and
// commit copies every shadow to the active registers in one cycle.
// Outputs a registered down-conversion phase and a widened, negated
// up-conversion phase per channel.
// Optional feature: define PHASE_DITHER_EN to add the low DITH_W bits of a
// shared 16-bit LFSR to the output phases. The accumulators are never dithered.
module nco_phase_bank #(
   parameter int unsigned CHW     = 1,
   parameter int unsigned PW      = 19,
   parameter int unsigned UPW     = 23,
   parameter int unsigned RST_INC = 80652,
   parameter int unsigned DITH_W  = 3
) (
   input  logic                      sys_clk,
   input  logic                      rst,
   input  logic                      ce,
   input  logic                      cfg_we,
   input  logic                      cfg_sel,
   input  logic [CHW-1:0]            cfg_ch,
   input  logic [PW-1:0]             cfg_data,
   input  logic                      commit,
   input  logic                      sync,
   input  logic [(2**CHW)-1:0]       sync_mask,
   output logic [(2**CHW)*PW-1:0]    phase_dn,
   output logic [(2**CHW)*UPW-1:0]   phase_up,
   output logic                      phase_vld,
   output logic                      commit_ack
);

   localparam int unsigned   NCH     = 2**CHW;
   localparam int unsigned   UPSH    = UPW - PW;
   localparam logic [PW-1:0] INC_RST = PW'(RST_INC);

   logic [PW-1:0]  sh_inc  [NCH];
   logic [PW-1:0]  sh_off  [NCH];
   logic [PW-1:0]  inc_fwd [NCH];
   logic [PW-1:0]  off_fwd [NCH];
   logic [PW-1:0]  act_inc [NCH];
   logic [PW-1:0]  act_off [NCH];
   logic [PW-1:0]  acc     [NCH];
   logic [PW-1:0]  ph_sum  [NCH];
   logic [UPW-1:0] up_nxt  [NCH];
   logic [PW-1:0]  dn_q    [NCH];
   logic [UPW-1:0] up_q    [NCH];
   logic [PW-1:0]  dith;

`ifdef PHASE_DITHER_EN
   logic [15:0] lfsr;

   // Shared Fibonacci LFSR (taps 16,14,13,11), stepped once per ce.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         lfsr <= 16'hACE1;
      end else if (ce) begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   // Dither is the pre-edge LFSR low bits, zero-extended to phase width.
   always_comb begin
      dith = PW'(lfsr[DITH_W-1:0]);
   end
`else
   // Dither disabled: outputs are the exact accumulated phase.
   always_comb begin
      dith = '0;
   end
`endif

   // Shadow registers take configuration writes at any time.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            sh_inc[i] <= INC_RST;
            sh_off[i] <= '0;
         end
      end else if (cfg_we) begin
         if (cfg_sel) begin
            sh_off[cfg_ch] <= cfg_data;
         end else begin
            sh_inc[cfg_ch] <= cfg_data;
         end
      end
   end

   // Commit source: shadow contents, with a same-cycle write forwarded so it
   // is committed together with the rest.
   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         inc_fwd[i] = sh_inc[i];
         off_fwd[i] = sh_off[i];
         if (cfg_we && (cfg_ch == CHW'(i))) begin
            if (cfg_sel) begin
               off_fwd[i] = cfg_data;
            end else begin
               inc_fwd[i] = cfg_data;
            end
         end
      end
   end

   // Active registers change only on commit, all channels at once.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            act_inc[i] <= INC_RST;
            act_off[i] <= '0;
         end
      end else if (commit) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            act_inc[i] <= inc_fwd[i];
            act_off[i] <= off_fwd[i];
         end
      end
   end

   // Phase accumulators. A masked sync wins over ce. The add uses the pre-edge
   // active increment, so a commit in the same cycle takes effect next ce.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            acc[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (sync && sync_mask[i]) begin
               acc[i] <= '0;
            end else if (ce) begin
               acc[i] <= acc[i] + act_inc[i];
            end
         end
      end
   end

   // Output phase from the pre-edge accumulator and offset. The up-phase is
   // the down-phase left-aligned to UPW bits and negated mod 2^UPW.
   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         ph_sum[i] = acc[i] + act_off[i] + dith;
         up_nxt[i] = '0 - (UPW'(ph_sum[i]) << UPSH);
      end
   end

   // Output registers advance only on ce and hold otherwise.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            dn_q[i] <= '0;
            up_q[i] <= '0;
         end
      end else if (ce) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            dn_q[i] <= ph_sum[i];
            up_q[i] <= up_nxt[i];
         end
      end
   end

   // Valid follows ce. The ack pulses once for every cycle in which commit was high.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         phase_vld  <= 1'b0;
         commit_ack <= 1'b0;
      end else begin
         phase_vld  <= ce;
         commit_ack <= commit;
      end
   end

   // Pack the per-channel registers onto the flat output buses.
   always_comb begin
      phase_dn = '0;
      phase_up = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         phase_dn[i*PW +: PW]   = dn_q[i];
         phase_up[i*UPW +: UPW] = up_q[i];
      end
   end

endmodule
